// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam int OP_W    = 4;

  localparam logic [OP_W-1:0] HALT_OP_DEFAULT = 4'hF;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  function automatic logic [OP_W-1:0] opcode_of(input instr_t word);
    return word[INSTR_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the memory-side and decode-side signals of the fetch sequencer.
interface fetch_ctrl_if #(
  parameter int CNT_W = 16
) ();
  import fetch_pkg::*;

  logic             start;
  pc_t              addr;
  instr_t           imem_data;
  logic             stall;
  logic             redirect;
  pc_t              redirect_addr;
  instr_t           out;
  pc_t              pc_out;
  logic             valid;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  start, imem_data, stall, redirect, redirect_addr,
    output addr, out, pc_out, valid, halted, fetch_count
  );

  modport slave (
    output start, imem_data, stall, redirect, redirect_addr,
    input  addr, out, pc_out, valid, halted, fetch_count
  );

endinterface

// File: rtl/fetch_ctrl_pc_next_sel.sv
// Next-PC mux: reset value, redirect target, increment with 8-bit wrap, or hold.
module pc_next_sel
  import fetch_pkg::*;
(
  input  logic rst_i,
  input  logic redirect_i,
  input  logic advance_i,
  input  pc_t  reset_pc_i,
  input  pc_t  redirect_addr_i,
  input  pc_t  pc_i,
  output pc_t  pc_d_o
);

  always_comb begin
    pc_d_o = pc_i;
    if (rst_i) begin
      pc_d_o = reset_pc_i;
    end else if (redirect_i) begin
      pc_d_o = redirect_addr_i;
    end else if (advance_i) begin
      pc_d_o = pc_i + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, captures memory words and hands
// them to decode with a valid/stall handshake, halting on HALT_OP.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter pc_t             RESET_PC = 8'd0,
  parameter logic [OP_W-1:0] HALT_OP  = HALT_OP_DEFAULT,
  parameter int              CNT_W    = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_ctrl_if.master bus
);

  fetch_state_e     state_q;
  pc_t              pc_q;
  pc_t              pc_d;
  instr_t           out_q;
  pc_t              pc_out_q;
  logic             valid_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  logic is_halt_word;
  logic advance;
  logic consume;

  assign is_halt_word = (opcode_of(bus.imem_data) == HALT_OP);
  // A halt word is delivered but the PC stays parked on it.
  assign advance = (state_q == ST_FETCH) && !bus.stall && !is_halt_word;
  assign consume = valid_q && !bus.stall;

  pc_next_sel u_pc_next_sel (
    .rst_i          (rst_i),
    .redirect_i     (bus.redirect),
    .advance_i      (advance),
    .reset_pc_i     (RESET_PC),
    .redirect_addr_i(bus.redirect_addr),
    .pc_i           (pc_q),
    .pc_d_o         (pc_d)
  );

  always_ff @(posedge clk_i) begin
    pc_q <= pc_d;
    if (rst_i) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (consume && !(&cnt_q)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.redirect) begin
            valid_q <= 1'b0;
          end else if (!bus.stall) begin
            out_q    <= bus.imem_data;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            if (is_halt_word) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (bus.redirect) begin
            state_q  <= ST_FETCH;
            halted_q <= 1'b0;
            valid_q  <= 1'b0;
          end else if (consume) begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr        = pc_q;
  assign bus.out         = out_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.valid       = valid_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int          CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [7:0]  RPC     = 8'd100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.CNT_W(CNT_W)) bus ();

  fetch_ctrl #(
    .RESET_PC(RPC),
    .HALT_OP (4'hF),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  logic [31:0] mem [256];
  always @(negedge clk) bus.imem_data = mem[bus.addr];

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0 waiting for start, 1 fetching, 2 stopped on halt.
  int          m_mode;
  logic [7:0]  m_pc, m_pc_out;
  logic [31:0] m_out;
  logic        m_valid, m_halted;
  int          m_cnt;

  function automatic logic [31:0] plain_word();
    logic [3:0]  op;
    logic [27:0] rest;
    op   = 4'($urandom_range(0, 14));
    rest = 28'($urandom);
    return {op, rest};
  endfunction

  task automatic tick();
    int          n_mode, n_cnt;
    logic [7:0]  n_pc, n_pc_out;
    logic [31:0] n_out, w;
    logic        n_valid, n_halted, consumed;
    n_mode = m_mode; n_cnt = m_cnt; n_pc = m_pc; n_pc_out = m_pc_out;
    n_out = m_out; n_valid = m_valid; n_halted = m_halted;
    w = mem[m_pc];
    consumed = m_valid && !bus.stall;
    if (rst) begin
      n_mode = 0; n_pc = RPC; n_out = '0; n_pc_out = '0;
      n_valid = 1'b0; n_halted = 1'b0; n_cnt = 0;
    end else begin
      if (consumed && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
      if (bus.redirect) n_pc = bus.redirect_addr;
      case (m_mode)
        0: if (bus.start) n_mode = 1;
        1: begin
          if (bus.redirect) n_valid = 1'b0;
          else if (!bus.stall) begin
            n_out = w; n_pc_out = m_pc; n_valid = 1'b1;
            if (w[31:28] == 4'hF) begin
              n_mode = 2; n_halted = 1'b1;
            end else begin
              n_pc = m_pc + 8'd1;
            end
          end
        end
        default: begin
          if (bus.redirect) begin
            n_mode = 1; n_halted = 1'b0; n_valid = 1'b0;
          end else if (consumed) n_valid = 1'b0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    m_mode = n_mode; m_cnt = n_cnt; m_pc = n_pc; m_pc_out = n_pc_out;
    m_out = n_out; m_valid = n_valid; m_halted = n_halted;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.start = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0;
    bus.redirect_addr = 8'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.out !== 32'd0 || bus.pc_out !== 8'd0 || bus.valid !== 1'b0 ||
        bus.halted !== 1'b0 || bus.fetch_count !== '0 || bus.addr !== RPC) begin
      fails++;
      $display("FAIL reset: addr=%h out=%h pc_out=%h valid=%b halted=%b cnt=%0d, want addr=%h and zeros",
               bus.addr, bus.out, bus.pc_out, bus.valid, bus.halted, bus.fetch_count, RPC);
    end
    repeat (3) tick();
    tests++;
    if (bus.valid !== 1'b0 || bus.addr !== RPC) begin
      fails++;
      $display("FAIL idle_no_start: valid=%b addr=%h, want 0 %h", bus.valid, bus.addr, RPC);
    end
  endtask

  task automatic test_basic();
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    tests++;
    if (bus.out !== 32'd12 || bus.pc_out !== 8'd100 || bus.valid !== 1'b1 ||
        bus.addr !== 8'd101 || bus.fetch_count !== 4'd0) begin
      fails++;
      $display("FAIL first_capture: out=%0d pc_out=%0d valid=%b addr=%0d cnt=%0d, want 12 100 1 101 0",
               bus.out, bus.pc_out, bus.valid, bus.addr, bus.fetch_count);
    end
    tick();
    tests++;
    if (bus.pc_out !== 8'd101 || bus.fetch_count !== 4'd1 || bus.out !== mem[101]) begin
      fails++;
      $display("FAIL second_capture: pc_out=%0d cnt=%0d out=%h, want 101 1 %h",
               bus.pc_out, bus.fetch_count, bus.out, mem[101]);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.redirect = 1'b1; bus.redirect_addr = 8'd120;
    tick();
    bus.redirect = 1'b0;
    tests++;
    if (bus.valid !== 1'b0 || bus.addr !== 8'd120 || bus.fetch_count !== 4'd0) begin
      fails++;
      $display("FAIL redirect_squash: valid=%b addr=%0d cnt=%0d, want 0 120 0",
               bus.valid, bus.addr, bus.fetch_count);
    end
    tick();
    tests++;
    if (bus.out !== 32'd5 || bus.pc_out !== 8'd120 || bus.valid !== 1'b1 || bus.fetch_count !== 4'd0) begin
      fails++;
      $display("FAIL redirect_target: out=%0d pc_out=%0d valid=%b cnt=%0d, want 5 120 1 0",
               bus.out, bus.pc_out, bus.valid, bus.fetch_count);
    end
    tick();
    tests++;
    if (bus.fetch_count !== 4'd1 || bus.pc_out !== 8'd121) begin
      fails++;
      $display("FAIL redirect_count: cnt=%0d pc_out=%0d, want 1 121", bus.fetch_count, bus.pc_out);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus.out !== 32'd12 || bus.pc_out !== 8'd100 || bus.valid !== 1'b1 ||
          bus.addr !== 8'd101 || bus.fetch_count !== 4'd0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: out=%0d pc_out=%0d valid=%b addr=%0d cnt=%0d, want 12 100 1 101 0",
                 i, bus.out, bus.pc_out, bus.valid, bus.addr, bus.fetch_count);
      end
    end
    bus.stall = 1'b0;
    tick();
    tests++;
    if (bus.pc_out !== 8'd101 || bus.fetch_count !== 4'd1 || bus.valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: pc_out=%0d cnt=%0d valid=%b, want 101 1 1",
               bus.pc_out, bus.fetch_count, bus.valid);
    end
  endtask

  task automatic test_halt();
    do_reset();
    bus.redirect = 1'b1; bus.redirect_addr = 8'd0;
    tick();
    bus.redirect = 1'b0;
    tests++;
    if (bus.addr !== 8'd0 || bus.valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_redirect: addr=%0d valid=%b, want 0 0", bus.addr, bus.valid);
    end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (3) tick();
    tests++;
    if (bus.out !== 32'hF000_0000 || bus.pc_out !== 8'd2 || bus.valid !== 1'b1 ||
        bus.halted !== 1'b1 || bus.addr !== 8'd2) begin
      fails++;
      $display("FAIL halt_deliver: out=%h pc_out=%0d valid=%b halted=%b addr=%0d, want f0000000 2 1 1 2",
               bus.out, bus.pc_out, bus.valid, bus.halted, bus.addr);
    end
    tick();
    tests++;
    if (bus.valid !== 1'b0 || bus.halted !== 1'b1 || bus.addr !== 8'd2 || bus.fetch_count !== 4'd3) begin
      fails++;
      $display("FAIL halt_park: valid=%b halted=%b addr=%0d cnt=%0d, want 0 1 2 3",
               bus.valid, bus.halted, bus.addr, bus.fetch_count);
    end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tests++;
    if (bus.halted !== 1'b1 || bus.addr !== 8'd2 || bus.valid !== 1'b0) begin
      fails++;
      $display("FAIL halt_ignores_start: halted=%b addr=%0d valid=%b, want 1 2 0",
               bus.halted, bus.addr, bus.valid);
    end
    bus.redirect = 1'b1; bus.redirect_addr = 8'd0;
    tick();
    bus.redirect = 1'b0;
    tests++;
    if (bus.halted !== 1'b0 || bus.addr !== 8'd0 || bus.valid !== 1'b0) begin
      fails++;
      $display("FAIL halt_exit: halted=%b addr=%0d valid=%b, want 0 0 0", bus.halted, bus.addr, bus.valid);
    end
    tick();
    tests++;
    if (bus.pc_out !== 8'd0 || bus.valid !== 1'b1 || bus.out !== mem[0]) begin
      fails++;
      $display("FAIL halt_restart: pc_out=%0d valid=%b out=%h, want 0 1 %h",
               bus.pc_out, bus.valid, bus.out, mem[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.redirect = 1'b1; bus.redirect_addr = 8'hFF;
    tick();
    bus.redirect = 1'b0;
    tick();
    tests++;
    if (bus.pc_out !== 8'hFF || bus.valid !== 1'b1 || bus.addr !== 8'h00) begin
      fails++;
      $display("FAIL wrap_ff: pc_out=%h valid=%b addr=%h, want ff 1 00", bus.pc_out, bus.valid, bus.addr);
    end
    tick();
    tests++;
    if (bus.pc_out !== 8'h00 || bus.addr !== 8'h01) begin
      fails++;
      $display("FAIL wrap_00: pc_out=%h addr=%h, want 00 01", bus.pc_out, bus.addr);
    end
  endtask

  task automatic test_count_sat();
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (10) tick();
    tests++;
    if (bus.fetch_count !== 4'd9) begin
      fails++;
      $display("FAIL count_mid: cnt=%0d, want 9", bus.fetch_count);
    end
    repeat (12) tick();
    tests++;
    if (bus.fetch_count !== 4'hF) begin
      fails++;
      $display("FAIL count_sat: cnt=%0d, want 15", bus.fetch_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    bus.stall = 1'b1; tick();
    rst = 1'b1; tick(); rst = 1'b0; bus.stall = 1'b0;
    tests++;
    if (bus.out !== 32'd0 || bus.pc_out !== 8'd0 || bus.valid !== 1'b0 ||
        bus.fetch_count !== '0 || bus.addr !== RPC) begin
      fails++;
      $display("FAIL reset_stalled: out=%h pc_out=%0d valid=%b cnt=%0d addr=%0d",
               bus.out, bus.pc_out, bus.valid, bus.fetch_count, bus.addr);
    end
    repeat (3) tick();
    tests++;
    if (bus.valid !== 1'b0 || bus.addr !== RPC) begin
      fails++;
      $display("FAIL reset_stalled_idle: valid=%b addr=%0d, want 0 %0d", bus.valid, bus.addr, RPC);
    end
    bus.start = 1'b1; bus.redirect = 1'b1; bus.redirect_addr = 8'd2;
    tick();
    bus.start = 1'b0; bus.redirect = 1'b0;
    tests++;
    if (bus.addr !== 8'd2) begin
      fails++;
      $display("FAIL start_redirect: addr=%0d, want 2", bus.addr);
    end
    repeat (2) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    tests++;
    if (bus.halted !== 1'b0 || bus.valid !== 1'b0 || bus.out !== 32'd0 ||
        bus.pc_out !== 8'd0 || bus.fetch_count !== '0 || bus.addr !== RPC) begin
      fails++;
      $display("FAIL reset_halted: halted=%b valid=%b out=%h pc_out=%0d cnt=%0d addr=%0d",
               bus.halted, bus.valid, bus.out, bus.pc_out, bus.fetch_count, bus.addr);
    end
    repeat (3) tick();
    tests++;
    if (bus.valid !== 1'b0 || bus.halted !== 1'b0 || bus.addr !== RPC) begin
      fails++;
      $display("FAIL reset_halted_idle: valid=%b halted=%b addr=%0d", bus.valid, bus.halted, bus.addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? {4'hF, 28'($urandom)} : plain_word();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst               = ($urandom_range(0, 99) == 0);
      bus.start         = ($urandom_range(0, 3) == 0);
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.redirect      = ($urandom_range(0, 9) == 0);
      bus.redirect_addr = 8'($urandom);
      tick();
      tests++;
      if (bus.addr !== m_pc || bus.out !== m_out || bus.pc_out !== m_pc_out ||
          bus.valid !== m_valid || bus.halted !== m_halted || bus.fetch_count !== CNT_W'(m_cnt)) begin
        fails++;
        $display("FAIL random[%0d]: got addr=%h out=%h pc=%h v=%b h=%b cnt=%0d want addr=%h out=%h pc=%h v=%b h=%b cnt=%0d",
                 c, bus.addr, bus.out, bus.pc_out, bus.valid, bus.halted, bus.fetch_count,
                 m_pc, m_out, m_pc_out, m_valid, m_halted, m_cnt);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = plain_word();
    mem[100] = 32'd12;
    mem[120] = 32'd5;
    mem[2]   = 32'hF000_0000;
    m_mode = 0; m_cnt = 0; m_pc = '0; m_pc_out = '0; m_out = '0;
    m_valid = 1'b0; m_halted = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_addr = 8'd0;

    test_reset();
    test_basic();
    test_redirect();
    test_stall();
    test_halt();
    test_wrap();
    test_count_sat();
    test_reset_mid();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that drives the 256 x 32 instruction memory.
- Owns the program counter and presents it as the memory read address.
- Captures the returned word and hands it downstream with a valid/stall handshake.
- Handles branch redirects, a halt opcode, and a delivered-instruction counter.
- Sits between the instruction memory and the decode stage of the single-cycle/pipelined CPU.

Parameters:
RESET_PC, 8'd0, PC value loaded on reset.
HALT_OP, 4'hF, opcode in instr[31:28] that halts fetch.
CNT_W, 16, width of the delivered-instruction counter.

Ports:
clk  input  1  system clock; all state changes on posedge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin fetching from the current PC (IDLE only).
addr  output  8  instruction memory read address; equals the PC register.
imem_data  input  32  instruction memory read data; memory updates it on negedge, so it is stable at the following posedge.
stall  input  1  downstream cannot accept; hold outputs.
redirect  input  1  load redirect_addr into PC and squash the current fetch.
redirect_addr  input  8  branch/jump target.
out  output  32  registered instruction to decode.
pc_out  output  8  PC of the instruction on out.
valid  output  1  out/pc_out hold a live instruction.
halted  output  1  fetch stopped on HALT_OP.
fetch_count  output  CNT_W  count of instructions delivered (valid and not stalled).

Behaviour:
- Reset (rst=1 at posedge, overrides everything, including mid-fetch or halt):
  - pc=RESET_PC, state=IDLE.
  - out=0, pc_out=0, valid=0, halted=0, fetch_count=0.
- addr is combinational from the pc register; there are no other combinational paths to outputs.
- Latency: PC presented in cycle N; the word is captured into out at the posedge ending cycle N; valid is high in cycle N+1.
- States are IDLE, FETCH, HALT.
- IDLE:
  - valid=0.
  - start=1 -> FETCH next cycle; pc unchanged.
  - redirect in IDLE loads pc but stays in IDLE.
- FETCH, priority redirect > stall > normal:
  - redirect=1: pc<=redirect_addr, valid<=0, no count increment; stall is ignored that cycle.
  - stall=1 (no redirect): pc, out, pc_out, valid all hold.
  - Normal: out<=imem_data, pc_out<=pc, valid<=1, pc<=pc+1 (mod 256; 8'hFF wraps to 8'h00).
  - fetch_count increments on every posedge where valid=1 and stall=0. It saturates at all-ones.
  - When a word with imem_data[31:28]==HALT_OP is captured (normal path): it is delivered with valid=1, state->HALT, pc does not advance.
- HALT:
  - halted=1.
  - valid drops to 0 once the halt instruction is consumed (valid & !stall); while stalled it stays presented.
  - redirect=1 -> pc<=redirect_addr, halted<=0, state->FETCH.
  - start is ignored in HALT.
- Simultaneous start and redirect in IDLE: pc<=redirect_addr, state->FETCH.

Decomposition:
- Package fetch_pkg:
  - state encoding (IDLE=2'd0, FETCH=2'd1, HALT=2'd2);
  - default HALT_OP;
  - PC width 8 and instruction width 32 constants.
- One combinational sub-module, pc_next_sel: next-PC mux covering redirect, hold, increment-with-wrap and reset value. Everything else stays in fetch_ctrl.

Test Plan:
- Memory word 12 at addr 100, word 5 at addr 120; RESET_PC=100, reset then start, no stall -> cycle after first capture: out=12, pc_out=100, valid=1; next cycle pc_out=101, fetch_count=1.
- In FETCH at pc=100, assert redirect with redirect_addr=120 -> valid=0 for that cycle; next capture out=5, pc_out=120; the count does not include the squashed word.
- Hold stall=1 for 3 cycles while out=12 is valid -> out, pc_out, valid and addr frozen; fetch_count unchanged; delivery resumes at pc_out=101 after release.
- Load 32'hF000_0000 at addr 2, RESET_PC=0 -> delivered at pc_out=2 with valid=1; then halted=1, valid=0, addr stuck at 2; redirect to 0 -> halted=0, fetch restarts at 0.
- Redirect to 8'hFF, run 2 cycles -> pc_out sequence 255, then 0 (wrap).
- Assert rst mid-stream while stalled, and again while halted -> next cycle all outputs zero, state IDLE, addr=RESET_PC; with start held low, no fetch occurs.
